// File: rtl/reg_stats_engine.sv
// reg_stats_engine
//   Host-loaded register file of DEPTH x WIDTH words with a one-word-per-cycle
//   scan that reports sum, floor average, odd count, min and max. With the
//   mode bit set, the same scan rewrites each word k < DEPTH-1 in place with
//   the floor average of itself and its upper neighbour. The statistics are
//   always computed from the pre-scan values.
module reg_stats_engine #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [WIDTH-1:0]    wr_data,
  input  logic [AW-1:0]       rd_addr,
  output logic [WIDTH-1:0]    rd_data,
  input  logic                go,
  input  logic                smooth_en,
  output logic                busy,
  output logic                done,
  output logic [WIDTH+AW-1:0] sum,
  output logic [WIDTH-1:0]    average,
  output logic [AW:0]         count_odd,
  output logic [WIDTH-1:0]    min_val,
  output logic [WIDTH-1:0]    max_val
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_SCAN  = 2'd2,
    S_FIN   = 2'd3
  } state_e;

  localparam logic [AW-1:0]    LAST_IDX = AW'(DEPTH - 1);
  localparam logic [AW-1:0]    IDX_ZERO = {AW{1'b0}};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

  // Architectural state
  state_e                state_q, state_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  mode_q, mode_d;
  logic [AW-1:0]         idx_q, idx_d;
  logic [WIDTH-1:0]      prev_q, prev_d;
  logic [WIDTH+AW-1:0]   sum_q, sum_d;
  logic [AW:0]           odd_q, odd_d;
  logic [WIDTH-1:0]      min_q, min_d;
  logic [WIDTH-1:0]      max_q, max_d;
  logic [WIDTH-1:0]      avg_q, avg_d;
  logic [WIDTH-1:0]      mem_q [DEPTH];

  // Datapath helpers
  logic [WIDTH-1:0]      cur_word_s;
  logic [WIDTH:0]        pair_sum_s;
  logic [WIDTH-1:0]      smooth_word_s;
  logic [AW-1:0]         smooth_addr_s;
  logic                  host_wr_s;
  logic                  smooth_wr_s;

  // Word under the scan pointer and its smoothed partner. The pair is added
  // one bit wider so the halving never loses a carry.
  always_comb begin
    cur_word_s    = mem_q[idx_q];
    pair_sum_s    = {1'b0, prev_q} + {1'b0, cur_word_s};
    smooth_word_s = WIDTH'(pair_sum_s >> 1);
    smooth_addr_s = idx_q - AW'(1);
  end

  // Next-state, accumulator and write-strobe logic for the scan FSM
  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    mode_d      = mode_q;
    idx_d       = idx_q;
    prev_d      = prev_q;
    sum_d       = sum_q;
    odd_d       = odd_q;
    min_d       = min_q;
    max_d       = max_q;
    avg_d       = avg_q;
    host_wr_s   = 1'b0;
    smooth_wr_s = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Host writes only land while idle; a write coinciding with go is
        // committed on the same edge, so the scan reads the new data.
        host_wr_s = wr_en;
        if (go) begin
          state_d = S_CLEAR;
          busy_d  = 1'b1;
          mode_d  = smooth_en;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_CLEAR: begin
        sum_d   = {(WIDTH+AW){1'b0}};
        odd_d   = {(AW+1){1'b0}};
        min_d   = ALL_ONES;
        max_d   = {WIDTH{1'b0}};
        idx_d   = IDX_ZERO;
        prev_d  = {WIDTH{1'b0}};
        state_d = S_SCAN;
      end

      S_SCAN: begin
        sum_d  = sum_q + {{AW{1'b0}}, cur_word_s};
        odd_d  = odd_q + {{AW{1'b0}}, cur_word_s[0]};
        if (cur_word_s < min_q) begin
          min_d = cur_word_s;
        end else begin
          min_d = min_q;
        end
        if (cur_word_s > max_q) begin
          max_d = cur_word_s;
        end else begin
          max_d = max_q;
        end
        // prev_q always holds the original value of the word below idx,
        // because that word is only overwritten one step after it is read.
        prev_d      = cur_word_s;
        smooth_wr_s = mode_q & (idx_q != IDX_ZERO);
        idx_d       = idx_q + AW'(1);
        if (idx_q == LAST_IDX) begin
          state_d = S_FIN;
        end else begin
          state_d = S_SCAN;
        end
      end

      S_FIN: begin
        avg_d   = sum_q[WIDTH+AW-1:AW];
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // FSM state and control/status registers
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      mode_q  <= mode_d;
    end
  end

  // Scan pointer and result accumulators
  always_ff @(posedge Clk) begin
    if (Rst) begin
      idx_q  <= IDX_ZERO;
      prev_q <= {WIDTH{1'b0}};
      sum_q  <= {(WIDTH+AW){1'b0}};
      odd_q  <= {(AW+1){1'b0}};
      min_q  <= {WIDTH{1'b0}};
      max_q  <= {WIDTH{1'b0}};
      avg_q  <= {WIDTH{1'b0}};
    end else begin
      idx_q  <= idx_d;
      prev_q <= prev_d;
      sum_q  <= sum_d;
      odd_q  <= odd_d;
      min_q  <= min_d;
      max_q  <= max_d;
      avg_q  <= avg_d;
    end
  end

  // Register file: reset clears every word; host and smoothing writes are
  // mutually exclusive because they belong to different FSM states.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
    end else if (host_wr_s) begin
      mem_q[wr_addr] <= wr_data;
    end else if (smooth_wr_s) begin
      mem_q[smooth_addr_s] <= smooth_word_s;
    end
  end

  assign rd_data   = mem_q[rd_addr];
  assign busy      = busy_q;
  assign done      = done_q;
  assign sum       = sum_q;
  assign average   = avg_q;
  assign count_odd = odd_q;
  assign min_val   = min_q;
  assign max_val   = max_q;

endmodule

// File: tb/tb_reg_stats_engine.sv
// Bench for reg_stats_engine (WIDTH=8, DEPTH=16): table of scan vectors with
// expected statistics, a scoreboard queue of expected results, plus
// hand-written sequences for reset mid-scan and write-with-go.
module tb_reg_stats_engine;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic                Clk = 1'b0;
  logic                Rst;
  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [WIDTH-1:0]    wr_data;
  logic [AW-1:0]       rd_addr;
  logic [WIDTH-1:0]    rd_data;
  logic                go;
  logic                smooth_en;
  logic                busy;
  logic                done;
  logic [WIDTH+AW-1:0] sum;
  logic [WIDTH-1:0]    average;
  logic [AW:0]         count_odd;
  logic [WIDTH-1:0]    min_val;
  logic [WIDTH-1:0]    max_val;

  reg_stats_engine #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .Clk(Clk), .Rst(Rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .go(go), .smooth_en(smooth_en),
    .busy(busy), .done(done),
    .sum(sum), .average(average), .count_odd(count_odd),
    .min_val(min_val), .max_val(max_val)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int          e_sum;
    int          e_avg;
    int          e_odd;
    int          e_min;
    int          e_max;
  } exp_t;

  typedef struct {
    int   pattern;   // 0: k, 1: 2k, 2: 0xFF, 3: odd k -> 0xFF else 0
    logic smooth;
    bit   inject;    // pulse go and wr_en while busy
    exp_t e;
  } vec_t;

  int   nchk = 0;
  int   nerr = 0;
  exp_t sb_q[$];
  int   orig[DEPTH];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int pat(input int p, input int k);
    case (p)
      0: return k;
      1: return 2 * k;
      2: return 255;
      3: return (k % 2 == 1) ? 255 : 0;
      default: return 0;
    endcase
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic load(input int p);
    for (int k = 0; k < DEPTH; k++) begin
      orig[k] = pat(p, k);
      wr_en   = 1'b1;
      wr_addr = AW'(k);
      wr_data = WIDTH'(orig[k]);
      tick();
    end
    wr_en = 1'b0;
  endtask

  // Expected array after a scan: smoothed pairs below the top word.
  task automatic check_mem(input string tag, input logic sm);
    int ev;
    for (int k = 0; k < DEPTH; k++) begin
      if (sm && k < DEPTH - 1) ev = (orig[k] + orig[k+1]) / 2;
      else ev = orig[k];
      rd_addr = AW'(k);
      #1;
      chk($sformatf("%s mem[%0d]", tag, k), rd_data, ev);
    end
  endtask

  task automatic run_scan(input string tag, input logic sm, input exp_t e,
                          input bit inject, input bit co_wr);
    int   cyc;
    int   extra;
    exp_t got;
    sb_q.push_back(e);
    smooth_en = sm;
    go        = 1'b1;
    if (co_wr) begin
      wr_en   = 1'b1;
      wr_addr = 4'd0;
      wr_data = 8'h11;
    end
    tick();
    go    = 1'b0;
    wr_en = 1'b0;
    cyc   = 0;
    chk({tag, " busy_after_go"}, busy, 1);
    while (!done && cyc < 40) begin
      if (inject && cyc == 3) begin
        go = 1'b1; wr_en = 1'b1; wr_addr = 4'd3; wr_data = 8'hAA;
      end else if (inject && cyc == 6) begin
        go = 1'b0; wr_en = 1'b0;
      end
      tick();
      cyc++;
    end
    go = 1'b0; wr_en = 1'b0;
    chk({tag, " latency"}, cyc, DEPTH + 2);
    chk({tag, " busy_at_done"}, busy, 0);
    if (sb_q.size() == 0) begin
      chk({tag, " scoreboard_empty"}, 1, 0);
    end else begin
      got = sb_q.pop_front();
      chk({tag, " sum"},       sum,       got.e_sum);
      chk({tag, " average"},   average,   got.e_avg);
      chk({tag, " count_odd"}, count_odd, got.e_odd);
      chk({tag, " min_val"},   min_val,   got.e_min);
      chk({tag, " max_val"},   max_val,   got.e_max);
    end
    extra = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done) extra++;
    end
    chk({tag, " single_done"}, extra, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[5];
    exp_t e;

    vecs[0] = '{0, 1'b0, 1'b0, '{120,   7,  8,   0,  15}};
    vecs[1] = '{1, 1'b1, 1'b0, '{240,  15,  0,   0,  30}};
    vecs[2] = '{2, 1'b1, 1'b0, '{4080, 255, 16, 255, 255}};
    vecs[3] = '{0, 1'b0, 1'b1, '{120,   7,  8,   0,  15}};
    vecs[4] = '{3, 1'b1, 1'b0, '{2040, 127, 8,   0, 255}};

    Rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_addr = '0; go = 1'b0; smooth_en = 1'b0;
    repeat (3) tick();
    Rst = 1'b0;
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst sum", sum, 0);
    chk("rst average", average, 0);
    chk("rst count_odd", count_odd, 0);
    chk("rst min_val", min_val, 0);
    chk("rst max_val", max_val, 0);
    for (int k = 0; k < DEPTH; k++) orig[k] = 0;
    check_mem("rst", 1'b0);

    for (int v = 0; v < 5; v++) begin
      load(vecs[v].pattern);
      run_scan($sformatf("vec%0d", v), vecs[v].smooth, vecs[v].e, vecs[v].inject, 1'b0);
      check_mem($sformatf("vec%0d", v), vecs[v].smooth);
    end

    // Reset mid-scan with smoothing active: partial writes are visible live,
    // then everything is wiped.
    load(1);
    smooth_en = 1'b1;
    go = 1'b1;
    tick();
    go = 1'b0;
    repeat (6) tick();
    rd_addr = 4'd0; #1;
    chk("midscan live mem[0]", rd_data, 1);
    rd_addr = 4'd5; #1;
    chk("midscan live mem[5]", rd_data, 10);
    chk("midscan busy", busy, 1);
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    chk("midrst busy", busy, 0);
    chk("midrst done", done, 0);
    chk("midrst sum", sum, 0);
    chk("midrst count_odd", count_odd, 0);
    chk("midrst min_val", min_val, 0);
    chk("midrst max_val", max_val, 0);
    for (int k = 0; k < DEPTH; k++) orig[k] = 0;
    check_mem("midrst", 1'b0);
    e = '{0, 0, 0, 0, 0};
    run_scan("after_rst", 1'b0, e, 1'b0, 1'b0);

    // Write and go in the same idle cycle: scan sees 0x11 at address 0.
    load(0);
    orig[0] = 17;
    e = '{137, 8, 9, 1, 17};
    run_scan("wr_with_go", 1'b0, e, 1'b0, 1'b1);
    check_mem("wr_with_go", 1'b0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
